// File: rtl/square_sprite_gen_if.sv
// square_sprite_gen_if: video timing into the sprite generator and registered VGA signals out
interface square_sprite_gen_if #(
    parameter int CORDW = 10,
    parameter int COLRW = 4
);
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             de;
    logic             hsync;
    logic             vsync;
    logic             vga_hsync;
    logic             vga_vsync;
    logic [COLRW-1:0] vga_r;
    logic [COLRW-1:0] vga_g;
    logic [COLRW-1:0] vga_b;

    modport master (
        output sx, sy, de, hsync, vsync,
        input  vga_hsync, vga_vsync, vga_r, vga_g, vga_b
    );

    modport slave (
        input  sx, sy, de, hsync, vsync,
        output vga_hsync, vga_vsync, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/square_sprite_gen.sv
// square_sprite_gen: draws a square that sits at the origin, bounces off the screen edges, or freezes
module square_sprite_gen #(
    parameter int                 CORDW   = 10,
    parameter int                 COLRW   = 4,
    parameter int                 H_RES   = 640,
    parameter int                 V_RES   = 480,
    parameter int                 SIZE    = 32,
    parameter int                 SPEED   = 2,
    parameter logic [3*COLRW-1:0] FG_COLR = 'h0FF,
    parameter logic [3*COLRW-1:0] BG_COLR = 'hFF0
) (
    input  logic               clk_pix,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    output logic               frame,
    square_sprite_gen_if.slave vid
);
    // All edge arithmetic is one bit wider than the coordinates so sums never wrap
    localparam int          W       = CORDW + 1;
    localparam logic [W-1:0] SIZE_W  = W'(SIZE);
    localparam logic [W-1:0] SPEED_W = W'(SPEED);
    localparam logic [W-1:0] H_W     = W'(H_RES);
    localparam logic [W-1:0] V_W     = W'(V_RES);

    logic [CORDW-1:0]   px_q, px_d, py_q, py_d;
    logic               dx_q, dx_d, dy_q, dy_d;
    logic [3*COLRW-1:0] rgb_q;
    logic               hs_q, vs_q, frame_q;
    logic               frame_tick, draw;
    logic [W-1:0]       sx_w, sy_w, px_w, py_w;

    // One axis of bounce motion; returns {direction, position}
    function automatic logic [W-1:0] bounce(input logic [W-1:0] p, input logic d, input logic [W-1:0] lim);
        if (d)
            return (p + SIZE_W + SPEED_W >= lim) ? {1'b0, CORDW'(lim - SIZE_W)} : {1'b1, CORDW'(p + SPEED_W)};
        return (p < SPEED_W) ? {1'b1, {CORDW{1'b0}}} : {1'b0, CORDW'(p - SPEED_W)};
    endfunction

    assign sx_w       = {1'b0, vid.sx};
    assign sy_w       = {1'b0, vid.sy};
    assign px_w       = {1'b0, px_q};
    assign py_w       = {1'b0, py_q};
    assign frame_tick = (vid.sy == CORDW'(V_RES)) && (vid.sx == '0);
    assign draw       = (sx_w >= px_w) && (sx_w < px_w + SIZE_W) && (sy_w >= py_w) && (sy_w < py_w + SIZE_W);

    // Next position: only the frame tick moves the square, so a frame is never torn
    always_comb begin
        {dx_d, px_d} = bounce(px_w, dx_q, H_W);
        {dy_d, py_d} = bounce(py_w, dy_q, V_W);
        if (!frame_tick || mode[1])
            {dx_d, px_d, dy_d, py_d} = {dx_q, px_q, dy_q, py_q};
        else if (!mode[0])
            {dx_d, px_d, dy_d, py_d} = {1'b1, {CORDW{1'b0}}, 1'b1, {CORDW{1'b0}}};
    end

    // Position and direction state
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            px_q <= '0;
            py_q <= '0;
            dx_q <= 1'b1;
            dy_q <= 1'b1;
        end else begin
            px_q <= px_d;
            py_q <= py_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    // Registered video outputs, one pixel behind the timing inputs
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            rgb_q   <= !vid.de ? '0 : draw ? FG_COLR : BG_COLR;
            hs_q    <= vid.hsync;
            vs_q    <= vid.vsync;
            frame_q <= frame_tick;
        end
    end

    assign frame                           = frame_q;
    assign vid.vga_hsync                   = hs_q;
    assign vid.vga_vsync                   = vs_q;
    assign {vid.vga_r, vid.vga_g, vid.vga_b} = rgb_q;
endmodule

// File: tb/tb_square_sprite_gen.sv
// tb_square_sprite_gen: table vectors, edge sequences and randomized probes against a position model
module tb_square_sprite_gen;
    localparam int          H  = 640;
    localparam int          V  = 480;
    localparam int          SZ = 32;
    localparam int          SP = 2;
    localparam logic [11:0] FG = 12'h0FF;
    localparam logic [11:0] BG = 12'hFF0;

    typedef struct {
        int          sx;
        int          sy;
        bit          de;
        bit          hs;
        bit          vs;
        logic [11:0] rgb;
        bit          ehs;
        bit          evs;
    } vec_t;

    logic       clk_pix = 1'b0;
    logic       rst_n   = 1'b0;
    logic [1:0] mode    = 2'b01;
    logic       frame;
    int         total   = 0;
    int         bad     = 0;
    int         mpx, mpy;
    bit         mdx, mdy;
    vec_t       vecs[10];

    square_sprite_gen_if #(.CORDW(10), .COLRW(4)) vid ();

    square_sprite_gen dut (
        .clk_pix(clk_pix),
        .rst_n  (rst_n),
        .mode   (mode),
        .frame  (frame),
        .vid    (vid)
    );

    always #5 clk_pix = ~clk_pix;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] rgb_now();
        return {vid.vga_r, vid.vga_g, vid.vga_b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        mpx = 0; mpy = 0; mdx = 1; mdy = 1;
    endfunction

    // A square bounces by reflecting off the far wall (clamped to lim-SZ) or the near wall (clamped to 0)
    task automatic move(inout int p, inout bit d, input int lim);
        if (d && p + SZ + SP >= lim) begin p = lim - SZ; d = 0; end
        else if (d)                  p = p + SP;
        else if (p < SP)             begin p = 0; d = 1; end
        else                         p = p - SP;
    endtask

    task automatic model_tick(input logic [1:0] m);
        if (m == 2'b00) model_reset();
        else if (m == 2'b01) begin
            move(mpx, mdx, H);
            move(mpy, mdy, V);
        end
    endtask

    function automatic logic [11:0] model_rgb(input int x, input int y, input bit de);
        if (!de) return 12'h000;
        return (x >= mpx && x < mpx + SZ && y >= mpy && y < mpy + SZ) ? FG : BG;
    endfunction

    task automatic drive(input int x, input int y, input bit de, input bit hs, input bit vs);
        vid.sx    = 10'(x);
        vid.sy    = 10'(y);
        vid.de    = de;
        vid.hsync = hs;
        vid.vsync = vs;
    endtask

    // One pixel cycle checked against the model; the model moves on the same edge as the DUT
    task automatic step(input int x, input int y, input bit de, input bit hs, input bit vs, input string tag);
        logic [11:0] er;
        bit          et;
        @(negedge clk_pix);
        drive(x, y, de, hs, vs);
        er = model_rgb(x, y, de);
        et = (x == 0 && y == V);
        @(posedge clk_pix);
        if (et) model_tick(mode);
        #1;
        chk({tag, ".rgb"}, rgb_now(), er);
        chk({tag, ".hs"}, vid.vga_hsync, hs);
        chk({tag, ".vs"}, vid.vga_vsync, vs);
        chk({tag, ".frame"}, frame, et);
    endtask

    task automatic tick();
        step(0, V, 0, 0, 1, "tick");
    endtask

    // A visible pixel with a hand-derived expected colour
    task automatic probe_exp(input int x, input int y, input logic [11:0] exp, input string tag);
        @(negedge clk_pix);
        drive(x, y, 1, 0, 0);
        @(posedge clk_pix);
        #1;
        chk(tag, rgb_now(), exp);
    endtask

    initial begin
        vecs[0] = '{2, 2, 1, 0, 0, FG, 0, 0};
        vecs[1] = '{1, 1, 1, 0, 0, BG, 0, 0};
        vecs[2] = '{33, 33, 1, 0, 0, FG, 0, 0};
        vecs[3] = '{34, 33, 1, 0, 0, BG, 0, 0};
        vecs[4] = '{33, 34, 1, 0, 0, BG, 0, 0};
        vecs[5] = '{2, 1, 1, 0, 0, BG, 0, 0};
        vecs[6] = '{10, 20, 0, 1, 0, 12'h000, 1, 0};
        vecs[7] = '{640, 10, 0, 0, 1, 12'h000, 0, 1};
        vecs[8] = '{639, 479, 1, 1, 1, BG, 1, 1};
        vecs[9] = '{20, 20, 1, 0, 1, FG, 0, 1};

        // Held in reset with active inputs: every output stays 0
        model_reset();
        drive(5, 5, 1, 1, 1);
        repeat (3) @(posedge clk_pix);
        #1;
        chk("rst.rgb", rgb_now(), 12'h000);
        chk("rst.hs", vid.vga_hsync, 1'b0);
        chk("rst.vs", vid.vga_vsync, 1'b0);
        chk("rst.frame", frame, 1'b0);
        @(negedge clk_pix);
        rst_n = 1'b1;

        // Square at the origin until the first tick, then at (2,2)
        step(0, 0, 1, 0, 0, "pre0");
        step(31, 31, 1, 0, 0, "pre31");
        step(32, 0, 1, 0, 0, "pre32");
        tick();
        step(100, 100, 1, 0, 0, "post");
        foreach (vecs[i]) begin
            @(negedge clk_pix);
            drive(vecs[i].sx, vecs[i].sy, vecs[i].de, vecs[i].hs, vecs[i].vs);
            @(posedge clk_pix);
            #1;
            chk($sformatf("vec%0d.rgb", i), rgb_now(), vecs[i].rgb);
            chk($sformatf("vec%0d.hs", i), vid.vga_hsync, vecs[i].ehs);
            chk($sformatf("vec%0d.vs", i), vid.vga_vsync, vecs[i].evs);
        end

        // hsync edge appears on vga_hsync exactly one edge later
        step(50, 50, 1, 0, 0, "hs0");
        @(negedge clk_pix);
        drive(50, 50, 1, 1, 0);
        #1;
        chk("hs.before", vid.vga_hsync, 1'b0);
        @(posedge clk_pix);
        #1;
        chk("hs.after", vid.vga_hsync, 1'b1);

        // Right edge: 606 -> 608 and turn, then back to 606
        for (int i = 0; i < 1000 && !(mpx == 606 && mdx); i++) tick();
        tick();
        probe_exp(608, mpy, FG, "r608.in");
        probe_exp(607, mpy, BG, "r608.left");
        probe_exp(639, mpy, FG, "r608.right");
        tick();
        probe_exp(606, mpy, FG, "r606.in");
        probe_exp(605, mpy, BG, "r606.left");
        probe_exp(637, mpy, FG, "r606.right");
        probe_exp(638, mpy, BG, "r606.out");

        // Freeze mid-frame at px=100, through three ticks (last one with reserved mode)
        for (int i = 0; i < 1000 && !(mpx == 100 && !mdx); i++) tick();
        step(200, 200, 1, 0, 0, "mid");
        mode = 2'b10;
        step(300, 10, 1, 0, 0, "mid2");
        for (int f = 0; f < 3; f++) begin
            if (f == 2) mode = 2'b11;
            tick();
            probe_exp(100, mpy, FG, $sformatf("frz%0d.l", f));
            probe_exp(99, mpy, BG, $sformatf("frz%0d.lo", f));
            probe_exp(131, mpy, FG, $sformatf("frz%0d.r", f));
            probe_exp(132, mpy, BG, $sformatf("frz%0d.ro", f));
        end
        mode = 2'b00;
        tick();
        probe_exp(0, 0, FG, "org.0");
        probe_exp(31, 31, FG, "org.31");
        probe_exp(32, 0, BG, "org.x32");
        probe_exp(0, 32, BG, "org.y32");

        // Randomized frames with random modes, probes clustered around the square
        for (int f = 0; f < 150; f++) begin
            int r;
            r = int'($urandom_range(0, 9));
            mode = (r < 6) ? 2'b01 : (r < 7) ? 2'b00 : (r < 9) ? 2'b10 : 2'b11;
            for (int k = 0; k < 15; k++) begin
                int x, y;
                bit de;
                if (k[0]) begin
                    x = int'($urandom_range(0, 799));
                    y = int'($urandom_range(0, 524));
                end else begin
                    x = mpx + int'($urandom_range(0, SZ + 4)) - 2;
                    y = mpy + int'($urandom_range(0, SZ + 4)) - 2;
                    if (x < 0) x = 0;
                    if (y < 0) y = 0;
                end
                de = (x < H && y < V) ? ($urandom_range(0, 7) != 0) : 1'b0;
                step(x, y, de, 1'($urandom), 1'($urandom), "rnd");
            end
            tick();
        end

        // Reset mid-frame at px=300: immediate zero outputs, motion restarts from the origin
        mode = 2'b00;
        tick();
        mode = 2'b01;
        for (int i = 0; i < 1000 && !(mpx == 300); i++) tick();
        step(mpx + 1, mpy + 1, 1, 1, 1, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.rgb", rgb_now(), 12'h000);
        chk("arst.hs", vid.vga_hsync, 1'b0);
        chk("arst.vs", vid.vga_vsync, 1'b0);
        chk("arst.frame", frame, 1'b0);
        model_reset();
        @(negedge clk_pix);
        rst_n = 1'b1;
        tick();
        probe_exp(2, 2, FG, "rel.in");
        probe_exp(1, 2, BG, "rel.left");
        probe_exp(33, 33, FG, "rel.corner");
        probe_exp(34, 2, BG, "rel.right");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
